// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive deserializer.
package uart_rx_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned MIN_DIV   = 2;
    localparam int unsigned STATE_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } rx_state_e;

    // Host-visible holding register and its sticky status
    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic                 full;
        logic                 frame_err;
        logic                 overrun;
    } rx_hold_t;

endpackage

// File: rtl/uart_rx_deser_if.sv
// Host-side bus of the UART receive deserializer (divisor, read strobe, data, status).
// With UART_RX_PARITY_EN defined the bus also carries parity_odd / parity_err.
interface uart_rx_deser_if #(
    parameter int unsigned DIV_W = 16
);
    logic [DIV_W-1:0] divisor;
    logic             rd_ack;
    logic [7:0]       rx_data;
    logic             rx_full;
    logic             frame_err;
    logic             overrun;
    logic             rx_busy;
`ifdef UART_RX_PARITY_EN
    logic             parity_odd;
    logic             parity_err;

    modport master (
        output divisor, rd_ack, parity_odd,
        input  rx_data, rx_full, frame_err, overrun, rx_busy, parity_err
    );

    modport slave (
        input  divisor, rd_ack, parity_odd,
        output rx_data, rx_full, frame_err, overrun, rx_busy, parity_err
    );
`else
    modport master (
        output divisor, rd_ack,
        input  rx_data, rx_full, frame_err, overrun, rx_busy
    );

    modport slave (
        input  divisor, rd_ack,
        output rx_data, rx_full, frame_err, overrun, rx_busy
    );
`endif
endinterface

// File: rtl/uart_rx_baud_cnt.sv
// Baud down-counter: latches/clamps the divisor at start detection and strobes on expiry.
module uart_rx_baud_cnt
    import uart_rx_pkg::*;
#(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] divisor,
    input  logic             load_half,
    input  logic             load_full,
    input  logic             en,
    output logic             expire_c
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_eff;

    // Divisors 0 and 1 cannot produce a mid-bit sample point, so run them as 2
    assign div_eff = (divisor < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : divisor;

    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q;
        if (load_half) begin
            div_d = div_eff;
            cnt_d = (div_eff >> 1) - DIV_W'(1);
        end else if (load_full) begin
            cnt_d = div_q - DIV_W'(1);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    assign expire_c = en && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= DIV_W'(MIN_DIV);
            cnt_q <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: synchronizes sin, recovers 8N1 frames and holds the last byte.
// Optional: define UART_RX_PARITY_EN to add a parity bit (8E1/8O1) with a sticky parity_err.
module uart_rx_deser
    import uart_rx_pkg::*;
#(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sin,
    uart_rx_deser_if.slave bus
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_in;
    rx_state_e              state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    rx_hold_t               hold_q, hold_d;
    logic                   rx_busy_q, rx_busy_d;
    logic                   load_half, load_full, expire_c, deliver;
`ifdef UART_RX_PARITY_EN
    logic                   par_odd_q, par_odd_d;
    logic                   par_bad_q, par_bad_d;
    logic                   parity_err_q, parity_err_d;
`endif

    // Metastability synchronizer; the oldest stage is the only copy of sin the logic sees
    assign sync_d = {sync_q[SYNC_STAGES-2:0], sin};
    assign s_in   = sync_q[SYNC_STAGES-1];

    uart_rx_baud_cnt #(
        .DIV_W (DIV_W)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .divisor   (DIV_W'(bus.divisor)),
        .load_half (load_half),
        .load_full (load_full),
        .en        (state_q != S_IDLE),
        .expire_c  (expire_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!s_in) state_d = S_START;
            end
            S_START: begin
                if (expire_c) state_d = s_in ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (expire_c && (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1))) begin
`ifdef UART_RX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (expire_c) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (expire_c) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output logic
    always_comb begin
        load_half = 1'b0;
        load_full = 1'b0;
        deliver   = 1'b0;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        hold_d    = hold_q;
        rx_busy_d = (state_d != S_IDLE);
`ifdef UART_RX_PARITY_EN
        par_odd_d    = par_odd_q;
        par_bad_d    = par_bad_q;
        parity_err_d = parity_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                load_half = !s_in;
`ifdef UART_RX_PARITY_EN
                if (!s_in) begin
                    par_odd_d = bus.parity_odd;
                    par_bad_d = 1'b0;
                end
`endif
            end
            S_START: begin
                if (expire_c && !s_in) begin
                    load_full = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (expire_c) begin
                    shift_d   = {s_in, shift_q[DATA_BITS-1:1]};
                    load_full = 1'b1;
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (expire_c) begin
                    load_full = 1'b1;
                    par_bad_d = ((^shift_q) ^ s_in) != par_odd_q;
                end
            end
`endif
            S_STOP: begin
                deliver = expire_c;
            end
            default: ;
        endcase

        // A read acknowledges the current byte and its flags; a same-cycle delivery lands on top
        if (bus.rd_ack) begin
            hold_d.full      = 1'b0;
            hold_d.frame_err = 1'b0;
            hold_d.overrun   = 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_d     = 1'b0;
`endif
        end

        if (deliver) begin
            if (!hold_q.full || bus.rd_ack) begin
                hold_d.data = shift_q;
                hold_d.full = 1'b1;
            end else begin
                hold_d.overrun = 1'b1;
            end
            if (!s_in) hold_d.frame_err = 1'b1;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) parity_err_d = 1'b1;
`endif
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '1;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            hold_q    <= '0;
            rx_busy_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_odd_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q    <= sync_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            rx_busy_q <= rx_busy_d;
`ifdef UART_RX_PARITY_EN
            par_odd_q    <= par_odd_d;
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.rx_data   = hold_q.data;
    assign bus.rx_full   = hold_q.full;
    assign bus.frame_err = hold_q.frame_err;
    assign bus.overrun   = hold_q.overrun;
    assign bus.rx_busy   = rx_busy_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser: directed table, hand-written corner cases, random frames.
module tb_uart_rx_deser;

    localparam int unsigned DIV_W = 16;
    localparam int unsigned SYNC  = 2;

    logic clk = 1'b0;
    logic rst;
    logic sin;

    uart_rx_deser_if #(.DIV_W(DIV_W)) bus ();

    uart_rx_deser #(
        .DIV_W       (DIV_W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sin (sin),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model of the host-visible holding register
    logic [7:0] m_data;
    logic       m_full, m_ferr, m_ovr;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         div;
        logic       ack_before;
        logic [7:0] exp_data;
        logic       exp_full;
        logic       exp_ferr;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".rx_data"},   32'(bus.rx_data),   32'(m_data));
        check({tag, ".rx_full"},   32'(bus.rx_full),   32'(m_full));
        check({tag, ".frame_err"}, 32'(bus.frame_err), 32'(m_ferr));
        check({tag, ".overrun"},   32'(bus.overrun),   32'(m_ovr));
    endtask

    task automatic model_reset();
        m_data = 8'h00;
        m_full = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic ack_pulse();
        bus.rd_ack = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b0;
        m_full = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // Drive one frame at the effective divisor; ack_idx >= 0 pulses rd_ack on that cycle
    task automatic send_frame(input logic [7:0] b, input logic stop, input int div,
                              input int ack_idx, input string tag);
        int d;
        int total;
        int bi;
        d = (div < 2) ? 2 : div;
        total = 11 * d + 4;
        bus.divisor = DIV_W'(div);
        for (int i = 0; i < total; i++) begin
            bi = i / d;
            if (bi == 0)      sin = 1'b0;
            else if (bi <= 8) sin = b[bi-1];
            else if (bi == 9) sin = stop;
            else              sin = 1'b1;
            bus.rd_ack = (i == ack_idx);
            @(negedge clk);
            if (i == 5 * d) check({tag, ".busy_mid"}, 32'(bus.rx_busy), 32'd1);
        end
        bus.rd_ack = 1'b0;
        if (ack_idx >= 0) begin
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end
        if (!m_full || ack_idx >= 0) begin
            m_data = b;
            m_full = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
        if (!stop) m_ferr = 1'b1;
        check({tag, ".busy_end"}, 32'(bus.rx_busy), 32'd0);
    endtask

    initial begin
        int d;
        int h;

        vecs[0] = '{8'h5A, 1'b1, 8,  1'b0, 8'h5A, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h33, 1'b1, 8,  1'b0, 8'h5A, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 1'b0, 1,  1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 3,  1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h81, 1'b0, 5,  1'b0, 8'hFF, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{8'h7E, 1'b1, 0,  1'b1, 8'h7E, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'hC3, 1'b1, 12, 1'b0, 8'h7E, 1'b1, 1'b0, 1'b1};

        // Reset with the line held low
        rst         = 1'b1;
        sin         = 1'b0;
        bus.divisor = DIV_W'(6);
        bus.rd_ack  = 1'b0;
`ifdef UART_RX_PARITY_EN
        bus.parity_odd = 1'b0;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        check_model("reset");
        check("reset.rx_busy", 32'(bus.rx_busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("release.rx_busy", 32'(bus.rx_busy), 32'd0);
        sin = 1'b1;
        repeat (20) @(negedge clk);
        check_model("release_idle");
        check("release_idle.rx_busy", 32'(bus.rx_busy), 32'd0);

        // Single frame then read
        send_frame(8'hCE, 1'b1, 6, -1, "single");
        check("single.rx_data", 32'(bus.rx_data), 32'hCE);
        check("single.rx_full", 32'(bus.rx_full), 32'd1);
        check_model("single");
        ack_pulse();
        @(negedge clk);
        check("single_ack.rx_full", 32'(bus.rx_full), 32'd0);
        check("single_ack.rx_data", 32'(bus.rx_data), 32'hCE);

        // Glitch: two low cycles at divisor 6 is shorter than a half bit
        bus.divisor = DIV_W'(6);
        sin = 1'b0;
        repeat (2) @(negedge clk);
        sin = 1'b1;
        @(negedge clk);
        check("glitch.busy_seen", 32'(bus.rx_busy), 32'd1);
        repeat (20) @(negedge clk);
        check("glitch.rx_busy", 32'(bus.rx_busy), 32'd0);
        check("glitch.rx_full", 32'(bus.rx_full), 32'd0);

        // Directed table
        for (int k = 0; k < 7; k++) begin
            if (vecs[k].ack_before) ack_pulse();
            send_frame(vecs[k].b, vecs[k].stop, vecs[k].div, -1, $sformatf("vec%0d", k));
            check($sformatf("vec%0d.rx_data", k),   32'(bus.rx_data),   32'(vecs[k].exp_data));
            check($sformatf("vec%0d.rx_full", k),   32'(bus.rx_full),   32'(vecs[k].exp_full));
            check($sformatf("vec%0d.frame_err", k), 32'(bus.frame_err), 32'(vecs[k].exp_ferr));
            check($sformatf("vec%0d.overrun", k),   32'(bus.overrun),   32'(vecs[k].exp_ovr));
        end

        // Read clears overrun and full together
        ack_pulse();
        @(negedge clk);
        check("ovr_clear.overrun", 32'(bus.overrun), 32'd0);
        check("ovr_clear.rx_full", 32'(bus.rx_full), 32'd0);
        check("ovr_clear.rx_data", 32'(bus.rx_data), 32'h7E);

        // rd_ack coincident with the stop-sample edge of a second byte
        send_frame(8'h3C, 1'b1, 6, -1, "pre_sim");
        d = 6;
        h = d / 2;
        send_frame(8'hA5, 1'b1, d, SYNC + h + 9 * d, "sim");
        check("sim.rx_data", 32'(bus.rx_data), 32'hA5);
        check("sim.rx_full", 32'(bus.rx_full), 32'd1);
        check("sim.overrun", 32'(bus.overrun), 32'd0);
        check_model("sim");

        // Random frames against the model
        for (int k = 0; k < 24; k++) begin
            logic [7:0] rb;
            logic       rstop;
            int         rdiv;
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 3) != 0);
            rdiv  = int'($urandom_range(0, 10));
            if ($urandom_range(0, 1) == 1) ack_pulse();
            send_frame(rb, rstop, rdiv, -1, $sformatf("rnd%0d", k));
            check_model($sformatf("rnd%0d", k));
        end

        // Reset in the middle of a frame abandons it
        ack_pulse();
        bus.divisor = DIV_W'(6);
        sin = 1'b0;
        repeat (6) @(negedge clk);
        sin = 1'b1;
        repeat (12) @(negedge clk);
        sin = 1'b0;
        repeat (12) @(negedge clk);
        check("midrst.busy_before", 32'(bus.rx_busy), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sin = 1'b1;
        model_reset();
        repeat (80) @(negedge clk);
        check_model("midrst");
        check("midrst.rx_busy", 32'(bus.rx_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
